parsed_msg_queue: RTL and testbench
===================================

PARSED_MSG_QUEUE -- requirements
Module: parsed_msg_queue

Interface
REQ-001 SHALL take parameter DEPTH, default 8: queue entries; power of two, >= 2.
REQ-002 SHALL take parameter TYPE_MASK, default 16'hFFFF: bit n = 1 accepts parsed_type n.
REQ-003 SHALL take parameter DROP_W, default 16: drop counter width.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port parsed_valid  in  1: one-cycle strobe, message fields valid.
REQ-007 SHALL have input ports parsed_type 4, order_ref 64, side 1, shares 32, price 32, new_order_ref 64, timestamp 48, misc_data 64: parser fields.
REQ-008 SHALL have port out_valid  out  1: head entry available.
REQ-009 SHALL have port out_ready  in  1: consumer accepts head.
REQ-010 SHALL have output ports out_type 4, out_order_ref 64, out_side 1, out_shares 32, out_price 32, out_new_order_ref 64, out_timestamp 48, out_misc_data 64: head entry fields.
REQ-011 SHALL have port count  out  $clog2(DEPTH)+1: current occupancy.
REQ-012 SHALL have port overflow  out  1: sticky flag, a message was dropped.
REQ-013 SHALL have port drop_count  out  DROP_W: messages dropped while full.

Function
REQ-014 SHALL store each entry as all eight fields, 309 bits total, in a circular buffer with wr_ptr/rd_ptr wrapping at DEPTH.
REQ-015 SHALL define accept = parsed_valid && TYPE_MASK[parsed_type].
REQ-016 SHALL silently discard filtered messages (accept = 0): no count, overflow or drop_count change.
REQ-017 SHALL define pop = out_valid && out_ready; out_ready while empty has no effect.
REQ-018 SHALL write on accept when count < DEPTH or pop is asserted in the same cycle.
REQ-019 SHALL, on a write, store the fields at wr_ptr and advance wr_ptr by 1 modulo DEPTH.
REQ-020 SHALL, on pop, advance rd_ptr by 1 modulo DEPTH.
REQ-021 SHALL update count by +1 on write only, -1 on pop only, and leave it unchanged when both or neither occur.
REQ-022 SHALL, on accept with count == DEPTH and no pop, drop the message: storage unchanged, overflow set to 1, drop_count += 1.
REQ-023 SHALL saturate drop_count at 2^DROP_W-1.
REQ-024 SHALL hold overflow at 1 until reset.
REQ-025 SHALL drive out_valid = (count != 0).
REQ-026 SHALL present out_* fields from the rd_ptr entry when out_valid = 1, and drive all out_* to 0 when empty.
REQ-027 SHALL have latency: message accepted on cycle N into an empty queue appears with out_valid = 1 on cycle N+1; no same-cycle fall-through.
REQ-028 SHALL, when out_valid = 1 and out_ready = 0, hold out_* and out_valid stable until pop.
REQ-029 SHALL preserve message order: FIFO, no reordering, no duplication.
REQ-030 SHALL, on accept and pop in the same cycle with count == 1, write the new entry and emit it on the next cycle with count staying 1.

Reset
REQ-031 SHALL, on rst assertion, immediately and asynchronously clear wr_ptr, rd_ptr, count, overflow, drop_count and out_valid, and drive all out_* to 0.
REQ-032 SHALL, on reset mid-operation, discard stored entries; the first accept after rst deassertion is the first entry output.
REQ-033 SHALL ignore parsed_valid and out_ready while rst = 1.
REQ-034 SHALL not require memory contents to be cleared by reset; occupancy is defined by the pointers only.

Verification
REQ-035 SHALL cover: after reset, one accepted Add (type 1, order_ref 0x1234, shares 100, price 0x00C35000) -> out_valid = 1 next cycle with exactly those fields, count 1; out_ready = 1 pops it -> count 0, out_* = 0.
REQ-036 SHALL cover: TYPE_MASK = 16'h0002, push types 1, 2, 3 -> only type 1 queued, count 1, drop_count 0, overflow 0.
REQ-037 SHALL cover: DEPTH = 8, out_ready = 0, push 10 messages -> count 8, drop_count 2, overflow 1; drain yields messages 1-8 in order.
REQ-038 SHALL cover: queue full, accept and pop in the same cycle -> new entry stored, count stays 8, drop_count unchanged.
REQ-039 SHALL cover: count 5, rst pulsed for 1 cycle mid-stream -> count 0, out_valid 0, overflow 0 asynchronously; next pushed message is output first.
REQ-040 SHALL cover: 3*DEPTH random push/pop cycles -> pointers wrap and the output sequence matches the scoreboard model exactly.

Source files
------------

// File: rtl/parsed_msg_queue.sv
// Circular-buffer queue of parsed market-data messages with a per-type accept mask.
// Accepted messages that arrive while the queue is full are dropped and counted.
module parsed_msg_queue #(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] TYPE_MASK = 16'hFFFF,
    parameter int          DROP_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     parsed_valid,
    input  logic [3:0]               parsed_type,
    input  logic [63:0]              order_ref,
    input  logic                     side,
    input  logic [31:0]              shares,
    input  logic [31:0]              price,
    input  logic [63:0]              new_order_ref,
    input  logic [47:0]              timestamp,
    input  logic [63:0]              misc_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_type,
    output logic [63:0]              out_order_ref,
    output logic                     out_side,
    output logic [31:0]              out_shares,
    output logic [31:0]              out_price,
    output logic [63:0]              out_new_order_ref,
    output logic [47:0]              out_timestamp,
    output logic [63:0]              out_misc_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]  msg_type;
        logic [63:0] order_ref;
        logic        side;
        logic [31:0] shares;
        logic [31:0] price;
        logic [63:0] new_order_ref;
        logic [47:0] timestamp;
        logic [63:0] misc_data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        wr_entry;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          accept;
    logic          pop;
    logic          wr;
    logic          drop;

    assign wr_entry = '{parsed_type, order_ref, side, shares, price,
                        new_order_ref, timestamp, misc_data};

    assign accept = parsed_valid && TYPE_MASK[parsed_type];
    assign pop    = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full queue can still take a write.
    assign wr     = accept && ((count < CW'(DEPTH)) || pop);
    assign drop   = accept && !wr;

    // Storage is not reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (wr && !rst)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

    assign out_valid = (count != '0);
    assign head      = out_valid ? mem[rd_ptr] : '0;

    assign out_type          = head.msg_type;
    assign out_order_ref     = head.order_ref;
    assign out_side          = head.side;
    assign out_shares        = head.shares;
    assign out_price         = head.price;
    assign out_new_order_ref = head.new_order_ref;
    assign out_timestamp     = head.timestamp;
    assign out_misc_data     = head.misc_data;

endmodule

// File: tb/tb_parsed_msg_queue.sv
// Scoreboard bench for parsed_msg_queue: directed pushes queue expected entries,
// a negedge monitor compares every popped head against the scoreboard front.
module tb_parsed_msg_queue;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [3:0]  msg_type;
        logic [63:0] order_ref;
        logic        side;
        logic [31:0] shares;
        logic [31:0] price;
        logic [63:0] new_order_ref;
        logic [47:0] timestamp;
        logic [63:0] misc_data;
    } msg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        parsed_valid = 1'b0;
    logic        f_valid = 1'b0;
    logic        out_ready = 1'b0;
    msg_t        din = '0;

    logic        out_valid;
    logic [3:0]  out_type;
    logic [63:0] out_order_ref;
    logic        out_side;
    logic [31:0] out_shares;
    logic [31:0] out_price;
    logic [63:0] out_new_order_ref;
    logic [47:0] out_timestamp;
    logic [63:0] out_misc_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    logic        f_out_valid;
    logic [3:0]  f_out_type;
    logic [63:0] f_out_order_ref;
    logic        f_out_side;
    logic [31:0] f_out_shares;
    logic [31:0] f_out_price;
    logic [63:0] f_out_new_order_ref;
    logic [47:0] f_out_timestamp;
    logic [63:0] f_out_misc_data;
    logic [3:0]  f_count;
    logic        f_overflow;
    logic [15:0] f_drop_count;

    int   n_cmp = 0;
    int   n_err = 0;
    msg_t exp_q[$];

    always #5 clk = ~clk;

    parsed_msg_queue #(.DEPTH(DEPTH), .TYPE_MASK(16'hFFFF), .DROP_W(16)) u_dut (
        .clk(clk), .rst(rst), .parsed_valid(parsed_valid),
        .parsed_type(din.msg_type), .order_ref(din.order_ref), .side(din.side),
        .shares(din.shares), .price(din.price), .new_order_ref(din.new_order_ref),
        .timestamp(din.timestamp), .misc_data(din.misc_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_order_ref(out_order_ref), .out_side(out_side),
        .out_shares(out_shares), .out_price(out_price),
        .out_new_order_ref(out_new_order_ref), .out_timestamp(out_timestamp),
        .out_misc_data(out_misc_data), .count(count), .overflow(overflow),
        .drop_count(drop_count)
    );

    parsed_msg_queue #(.DEPTH(DEPTH), .TYPE_MASK(16'h0002), .DROP_W(16)) u_filt (
        .clk(clk), .rst(rst), .parsed_valid(f_valid),
        .parsed_type(din.msg_type), .order_ref(din.order_ref), .side(din.side),
        .shares(din.shares), .price(din.price), .new_order_ref(din.new_order_ref),
        .timestamp(din.timestamp), .misc_data(din.misc_data),
        .out_valid(f_out_valid), .out_ready(1'b0),
        .out_type(f_out_type), .out_order_ref(f_out_order_ref), .out_side(f_out_side),
        .out_shares(f_out_shares), .out_price(f_out_price),
        .out_new_order_ref(f_out_new_order_ref), .out_timestamp(f_out_timestamp),
        .out_misc_data(f_out_misc_data), .count(f_count), .overflow(f_overflow),
        .drop_count(f_drop_count)
    );

    function automatic msg_t mk(int id, logic [3:0] t);
        msg_t m;
        m.msg_type      = t;
        m.order_ref     = 64'hA000_0000_0000_0000 | 64'(id);
        m.side          = id[0];
        m.shares        = 32'(id * 10);
        m.price         = 32'h1000 + 32'(id);
        m.new_order_ref = ~m.order_ref;
        m.timestamp     = 48'h1_0000 + 48'(id);
        m.misc_data     = {32'(id), 32'(id)};
        return m;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one message for one cycle; store_exp says whether it should land in the queue.
    task automatic push(msg_t m, bit store_exp);
        din = m;
        parsed_valid = 1'b1;
        if (store_exp) exp_q.push_back(m);
        tick();
        parsed_valid = 1'b0;
    endtask

    task automatic drain(string nm);
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (count != 0 && guard < 4 * DEPTH) begin
            tick();
            guard++;
        end
        out_ready = 1'b0;
        chk({nm, "_count"}, 64'(count), 64'd0);
        chk({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: a handshake seen at negedge is consumed on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            msg_t act;
            msg_t req;
            act = {out_type, out_order_ref, out_side, out_shares, out_price,
                   out_new_order_ref, out_timestamp, out_misc_data};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got %h expected no entry", act);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    n_err++;
                    $display("FAIL pop_data: got %h expected %h", act, req);
                end
            end
        end
    end

    initial begin
        msg_t add;
        int   mcount;
        int   mdrop;

        // Reset state
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_out_ref", out_order_ref, 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single Add message, one-cycle latency, then pop
        add = '0;
        add.msg_type  = 4'd1;
        add.order_ref = 64'h1234;
        add.shares    = 32'd100;
        add.price     = 32'h00C3_5000;
        push(add, 1'b1);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_count", 64'(count), 64'd1);
        chk("add_type", 64'(out_type), 64'd1);
        chk("add_ref", out_order_ref, 64'h1234);
        chk("add_shares", 64'(out_shares), 64'd100);
        chk("add_price", 64'(out_price), 64'h00C3_5000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("add_pop_count", 64'(count), 64'd0);
        chk("add_pop_valid", 64'(out_valid), 64'd0);
        chk("add_pop_ref", out_order_ref, 64'd0);
        chk("add_pop_price", 64'(out_price), 64'd0);

        // Type filter on the masked instance: only type 1 passes
        for (int t = 1; t <= 3; t++) begin
            din = mk(40 + t, 4'(t));
            f_valid = 1'b1;
            tick();
        end
        f_valid = 1'b0;
        chk("filt_count", 64'(f_count), 64'd1);
        chk("filt_type", 64'(f_out_type), 64'd1);
        chk("filt_ref", f_out_order_ref, 64'hA000_0000_0000_0029);
        chk("filt_drop", 64'(f_drop_count), 64'd0);
        chk("filt_overflow", 64'(f_overflow), 64'd0);

        // Fill past capacity: 10 pushes, last 2 dropped
        for (int i = 1; i <= 10; i++)
            push(mk(i, 4'(i)), i <= DEPTH);
        chk("full_count", 64'(count), 64'd8);
        chk("full_drop", 64'(drop_count), 64'd2);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_head_ref", out_order_ref, 64'hA000_0000_0000_0001);

        // Full with simultaneous pop: new message stored, no drop
        out_ready = 1'b1;
        push(mk(11, 4'd11), 1'b1);
        out_ready = 1'b0;
        chk("fullpop_count", 64'(count), 64'd8);
        chk("fullpop_drop", 64'(drop_count), 64'd2);
        drain("fill_drain");
        chk("overflow_sticky", 64'(overflow), 64'd1);

        // Reset mid-stream with count 5; inputs during reset are ignored
        for (int i = 20; i < 25; i++)
            push(mk(i, 4'd2), 1'b0);
        chk("pre_rst_count", 64'(count), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_drop", 64'(drop_count), 64'd0);
        chk("arst_out_ref", out_order_ref, 64'd0);
        din = mk(99, 4'd3);
        parsed_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        parsed_valid = 1'b0;
        out_ready = 1'b0;
        chk("post_rst_count", 64'(count), 64'd0);
        push(mk(100, 4'd5), 1'b1);
        chk("post_rst_head", out_order_ref, 64'hA000_0000_0000_0064);
        drain("rst_drain");

        // Random push/pop traffic over several pointer wraps
        mcount = 0;
        mdrop = 0;
        for (int c = 0; c < 6 * DEPTH; c++) begin
            bit v, r, p, w;
            v = 1'($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 2) == 0);
            p = (mcount != 0) && r;
            w = v && (mcount < DEPTH || p);
            din = mk(200 + c, 4'(c));
            parsed_valid = v;
            out_ready = r;
            if (w) exp_q.push_back(din);
            if (v && !w) mdrop++;
            mcount = mcount + (w ? 1 : 0) - (p ? 1 : 0);
            tick();
        end
        parsed_valid = 1'b0;
        out_ready = 1'b0;
        chk("rand_count", 64'(count), 64'(mcount));
        chk("rand_drop", 64'(drop_count), 64'(mdrop));
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
